// File: rtl/logic_unit_pipe.sv
// Single-stage registered bitwise logic unit (OR/AND/XOR/NOR) with valid/ready
// handshakes on both sides and an optional accumulator that can replace operand B.
module logic_unit_pipe #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             c_any,
  output logic [WIDTH-1:0] acc_q
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  typedef enum logic [1:0] {OP_OR = 2'b00, OP_AND = 2'b01, OP_XOR = 2'b10, OP_NOR = 2'b11} op_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = (state == FULL);
  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign in_ready  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign c     = c_q;
  assign c_any = |c_q;
  assign acc_q = acc_r;

  // A clear coinciding with an accumulate uses ACC_INIT as the seed operand.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    operand_b = b;
    if (acc) operand_b = clr ? ACC_INIT : acc_r;
  end

  always_comb begin
    result = '0;
    case (op_t'(op))
      OP_OR:   result = a | operand_b;
      OP_AND:  result = a & operand_b;
      OP_XOR:  result = a ^ operand_b;
      OP_NOR:  result = ~(a | operand_b);
      default: result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (in_xfer) state_next = FULL;
      FULL:    if (out_xfer && !in_xfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state <= EMPTY;
      c_q   <= '0;
      acc_r <= ACC_INIT;
    end else begin
      state <= state_next;
      if (in_xfer) c_q <= result;
      if (in_xfer && acc) acc_r <= result;
      else if (clr)       acc_r <= ACC_INIT;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe: vector table plus
// hand-written backpressure, streaming, clear and reset sequences.
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             acc;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             c_any;
  logic [WIDTH-1:0] acc_q;

  int n_checks = 0;
  int n_fail   = 0;

  logic_unit_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc(acc), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .c_any(c_any), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       acc;
    logic       clr;
    logic [7:0] exp_c;
    logic       exp_any;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
    case (o)
      2'b00:   return x | y;
      2'b01:   return x & y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  initial begin
    logic [7:0] sa, sb, exp;
    logic [1:0] sop;

    vecs[0]  = '{8'h0F, 8'hF0, 2'b00, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00};
    vecs[1]  = '{8'h0F, 8'hF0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{8'h0F, 8'hF0, 2'b10, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00};
    vecs[3]  = '{8'h0F, 8'hF0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{8'h01, 8'hAA, 2'b00, 1'b1, 1'b0, 8'h01, 1'b1, 8'h01};
    vecs[5]  = '{8'h04, 8'hAA, 2'b00, 1'b1, 1'b0, 8'h05, 1'b1, 8'h05};
    vecs[6]  = '{8'h80, 8'hAA, 2'b00, 1'b1, 1'b0, 8'h85, 1'b1, 8'h85};
    vecs[7]  = '{8'h7A, 8'h00, 2'b00, 1'b1, 1'b0, 8'hFF, 1'b1, 8'hFF};
    vecs[8]  = '{8'h55, 8'h12, 2'b10, 1'b1, 1'b1, 8'h55, 1'b1, 8'h55};
    vecs[9]  = '{8'h33, 8'h0F, 2'b01, 1'b0, 1'b1, 8'h03, 1'b1, 8'h00};
    vecs[10] = '{8'h0F, 8'h77, 2'b11, 1'b1, 1'b0, 8'hF0, 1'b1, 8'hF0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    acc = 1'b0; clr = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_c",         64'(c),         64'h00);
    check("reset_c_any",     64'(c_any),     64'd0);
    check("reset_acc_q",     64'(acc_q),     64'h00);
    check("reset_in_ready",  64'(in_ready),  64'd1);

    // Back-to-back vectors, one transfer per cycle, consumer always ready.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
      acc = vecs[i].acc; clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d_c", i),         64'(c),         64'(vecs[i].exp_c));
      check($sformatf("vec%0d_c_any", i),     64'(c_any),     64'(vecs[i].exp_any));
      check($sformatf("vec%0d_acc_q", i),     64'(acc_q),     64'(vecs[i].exp_acc));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
    end

    // Clear alone while draining: acc resets, output drains, c holds.
    in_valid = 1'b0; acc = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_alone_acc_q",     64'(acc_q),     64'h00);
    check("clr_alone_out_valid", 64'(out_valid), 64'd0);
    check("clr_alone_c_hold",    64'(c),         64'hF0);

    // Backpressure: 0x3C held for three stalled cycles.
    in_valid = 1'b1; a = 8'h3C; b = 8'h00; op = 2'b00;
    tick();
    check("bp_load_c", 64'(c), 64'h3C);
    out_ready = 1'b0; a = 8'h11;
    #1;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp%0d_c", i),         64'(c),         64'h3C);
      check($sformatf("bp%0d_c_any", i),     64'(c_any),     64'd1);
      check($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_in_ready", i),  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp_release_c",         64'(c),         64'h11);
    check("bp_release_out_valid", 64'(out_valid), 64'd1);

    // Streaming at full throughput with random operands.
    for (int i = 0; i < 16; i++) begin
      sa = 8'($urandom_range(0, 255));
      sb = 8'($urandom_range(0, 255));
      sop = 2'($urandom_range(0, 3));
      exp = model(sa, sb, sop);
      a = sa; b = sb; op = sop;
      tick();
      check($sformatf("stream%0d_c", i),         64'(c),         64'(exp));
      check($sformatf("stream%0d_c_any", i),     64'(c_any),     64'(|exp));
      check($sformatf("stream%0d_out_valid", i), 64'(out_valid), 64'd1);
    end

    // Reset while FULL and stalled discards the pending result.
    a = 8'hAA; op = 2'b00; acc = 1'b1;
    tick();
    check("pre_rst_acc_q", 64'(acc_q), 64'hAA);
    out_ready = 1'b0; acc = 1'b0; a = 8'h5A; clr = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("rst_full_out_valid", 64'(out_valid), 64'd0);
    check("rst_full_c",         64'(c),         64'h00);
    check("rst_full_c_any",     64'(c_any),     64'd0);
    check("rst_full_acc_q",     64'(acc_q),     64'h00);
    check("rst_full_in_ready",  64'(in_ready),  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
